// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sweep scheduler.
package acq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } sweep_state_t;

  localparam logic [1:0] CFG_MASK  = 2'd0;
  localparam logic [1:0] CFG_DECIM = 2'd1;
  localparam logic [1:0] CFG_CLR   = 2'd2;

  localparam int OVR_CNT_WIDTH = 8;

  function automatic logic [OVR_CNT_WIDTH-1:0] sat_inc(input logic [OVR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/acq_sweep_scheduler_if.sv
// Shadow read port, sample stream, config port and status of the sweep scheduler.
// Stream: a sample moves on a rising sys_clk edge where out_valid && out_ready;
// once out_valid rises, out_data/out_channel/out_last hold until that edge.
interface acq_sweep_scheduler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int CH_ID_WIDTH = 4
);
  import acq_pkg::*;

  logic                   frame_start;
  logic                   rd_en;
  logic [CH_ID_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [CH_ID_WIDTH-1:0] out_channel;
  logic                   out_last;
  logic                   out_ready;
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [31:0]            cfg_wdata;
  logic                   busy;
  logic                   frame_done;
  logic                   overrun;
  logic [7:0]             overrun_cnt;
  sweep_state_t           dbg_state;

  modport master (
    input  frame_start, rd_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output rd_en, rd_addr, out_valid, out_data, out_channel, out_last,
           busy, frame_done, overrun, overrun_cnt, dbg_state
  );

  modport slave (
    output frame_start, rd_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  rd_en, rd_addr, out_valid, out_data, out_channel, out_last,
           busy, frame_done, overrun, overrun_cnt, dbg_state
  );

endinterface

// File: rtl/acq_sweep_scheduler_chan_mask_next.sv
// Priority encoder: lowest enabled channel strictly above idx (idx = -1 finds the first).
module chan_mask_next #(
  parameter int NUM_CHANNELS = 16,
  parameter int CH_ID_WIDTH  = 4
) (
  input  logic [NUM_CHANNELS-1:0]  mask,
  input  logic signed [CH_ID_WIDTH:0] idx,
  output logic [CH_ID_WIDTH-1:0]   nxt,
  output logic                     none
);

  // Descending scan so the lowest qualifying channel is the last one written.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        nxt  = CH_ID_WIDTH'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/acq_sweep_scheduler.sv
// Walks the enabled channels of the shadow snapshot on each selected frame start
// and streams one sample per channel, with decimation and overrun accounting.
module acq_sweep_scheduler
  import acq_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int CH_ID_WIDTH  = 4,
  parameter int DECIM_WIDTH  = 8,
  parameter logic [NUM_CHANNELS-1:0] MASK_RESET = '1
) (
  input  logic               sys_clk,
  input  logic               rst,
  acq_sweep_scheduler_if.master bus
);

  sweep_state_t              state_q, state_n;
  logic [CH_ID_WIDTH-1:0]    ptr_q, ptr_n;
  logic [DECIM_WIDTH-1:0]    dcnt_q, d_use, dcnt_adv;
  logic [NUM_CHANNELS-1:0]   mask_q, act_mask_q;
  logic [DECIM_WIDTH-1:0]    d_q, act_d_q;
  logic                      rd_en_q;
  logic [CH_ID_WIDTH-1:0]    rd_addr_q;
  logic                      out_valid_q, out_last_q, busy_q, done_q, done_n;
  logic [DATA_WIDTH-1:0]     out_data_q;
  logic [CH_ID_WIDTH-1:0]    out_channel_q;
  logic                      ovr_q;
  logic [OVR_CNT_WIDTH-1:0]  ovr_cnt_q;

  logic                      selected, accept, ovr_event;
  logic                      wr_mask, wr_decim, wr_clr;
  logic [CH_ID_WIDTH-1:0]    next_idx, first_idx;
  logic                      next_none, first_none;
  logic                      unused_cfg_bits;

  assign unused_cfg_bits = ^bus.cfg_wdata;

  chan_mask_next #(.NUM_CHANNELS(NUM_CHANNELS), .CH_ID_WIDTH(CH_ID_WIDTH)) u_next (
    .mask (act_mask_q),
    .idx  ($signed({1'b0, ptr_q})),
    .nxt  (next_idx),
    .none (next_none)
  );

  chan_mask_next #(.NUM_CHANNELS(NUM_CHANNELS), .CH_ID_WIDTH(CH_ID_WIDTH)) u_first (
    .mask (mask_q),
    .idx  ('1),
    .nxt  (first_idx),
    .none (first_none)
  );

  assign selected  = bus.frame_start && (dcnt_q == '0);
  assign accept    = selected && (state_q == IDLE);
  assign ovr_event = selected && (state_q != IDLE);
  assign wr_mask   = bus.cfg_we && (bus.cfg_addr == CFG_MASK);
  assign wr_decim  = bus.cfg_we && (bus.cfg_addr == CFG_DECIM);
  assign wr_clr    = bus.cfg_we && (bus.cfg_addr == CFG_CLR);

  // An accepted frame wraps against the D it is about to snapshot, so a fresh D applies immediately.
  assign d_use    = accept ? d_q : act_d_q;
  assign dcnt_adv = (dcnt_q == d_use) ? '0 : dcnt_q + 1'b1;

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (first_none) begin
            done_n = 1'b1;
          end else begin
            ptr_n   = first_idx;
            state_n = FETCH;
          end
        end
      end
      FETCH:   state_n = CAPTURE;
      CAPTURE: state_n = EMIT;
      EMIT: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            ptr_n   = next_idx;
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so none depend combinationally on inputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      rd_en_q     <= (state_n == FETCH);
      rd_addr_q   <= ptr_n;
      out_valid_q <= (state_n == EMIT);
      busy_q      <= (state_n != IDLE);
      done_q      <= done_n;
      if (state_q == CAPTURE) begin
        out_data_q    <= bus.rd_data;
        out_channel_q <= ptr_q;
        out_last_q    <= next_none;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mask_q     <= MASK_RESET;
      d_q        <= '0;
      act_mask_q <= MASK_RESET;
      act_d_q    <= '0;
      dcnt_q     <= '0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      if (wr_mask)  mask_q <= bus.cfg_wdata[NUM_CHANNELS-1:0];
      if (wr_decim) d_q    <= bus.cfg_wdata[DECIM_WIDTH-1:0];
      if (accept) begin
        act_mask_q <= mask_q;
        act_d_q    <= d_q;
      end
      if (wr_decim)             dcnt_q <= '0;
      else if (bus.frame_start) dcnt_q <= dcnt_adv;
      if (wr_clr) begin
        ovr_q     <= 1'b0;
        ovr_cnt_q <= '0;
      end else if (ovr_event) begin
        ovr_q     <= 1'b1;
        ovr_cnt_q <= sat_inc(ovr_cnt_q);
      end
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.overrun     = ovr_q;
  assign bus.overrun_cnt = ovr_cnt_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: doc/acq_sweep_scheduler.md
# acq_sweep_scheduler

Sequences readout of the captured channel snapshot into the neural acquisition frontend in the `sys_clk` domain. On each synchronized frame-start pulse it walks only the enabled channels in ascending order and reads each from the shadow-register read port. It presents each sample on a valid/ready stream and applies frame decimation. It reports dropped frames (overruns) through sticky status and a counter. Configuration is via a small register write port and takes effect at frame boundaries.

## Interface
Parameters:
- `NUM_CHANNELS`, 16: channels in snapshot.
- `DATA_WIDTH`, 16: sample width.
- `CH_ID_WIDTH`, 4: channel index width; must satisfy 2^CH_ID_WIDTH ≥ NUM_CHANNELS.
- `DECIM_WIDTH`, 8: decimation register width.
- `MASK_RESET`, all ones: enable mask value after reset.

Ports:
- `sys_clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse, already synchronized to `sys_clk`.
- `rd_en` out 1: shadow read strobe.
- `rd_addr` out CH_ID_WIDTH: shadow read index.
- `rd_data` in DATA_WIDTH: valid the cycle after `rd_en`.
- `out_valid` out 1: sample valid.
- `out_data` out DATA_WIDTH: sample value.
- `out_channel` out CH_ID_WIDTH: sample channel index.
- `out_last` out 1: last enabled channel of the frame.
- `out_ready` in 1: downstream accept.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 2: register select. 0 = enable mask, 1 = decimation D, 2 = clear overrun; 3 is ignored.
- `cfg_wdata` in 32: write data, LSB-aligned.
- `busy` out 1: sweep in progress.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `overrun` out 1: sticky dropped-frame flag.
- `overrun_cnt` out 8: saturating count of dropped frames.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, EMIT.
- **Decimation counter `dcnt`** (DECIM_WIDTH bits):
  - Advances on every `frame_start`.
  - Wraps to 0 after reaching the active D.
  - A frame is selected when `dcnt == 0`. D = 0 selects every frame.
- **IDLE + selected `frame_start`:**
  - Snapshot the mask and D into active copies.
  - Mask non-zero: set `ptr` to the lowest enabled channel and go to FETCH.
  - Mask zero: stay IDLE and pulse `frame_done` the next cycle; no samples are emitted.
- **FETCH:** `rd_en = 1`, `rd_addr = ptr`. Go to CAPTURE.
- **CAPTURE:** register `rd_data` into `out_data`, `ptr` into `out_channel`, and "no higher enabled bit" into `out_last`. Go to EMIT.
- **EMIT:** hold `out_valid` high with the output fields stable until `out_ready`. On transfer:
  - `out_last = 0`: `ptr` becomes the next higher enabled channel, go to FETCH.
  - `out_last = 1`: go to IDLE and pulse `frame_done`.
- `busy` is 1 in any state other than IDLE.
- **Overrun:** a selected `frame_start` while `busy`:
  - The frame is dropped and the current sweep continues unaffected.
  - `overrun` is set and `overrun_cnt` increments, saturating at 255.
  - A non-selected `frame_start` while `busy` is not an overrun.
- **Config writes:**
  - The mask and D registers take effect at the next accepted frame only.
  - Mask bits at or above NUM_CHANNELS are ignored.
  - A write to address 2 clears `overrun` and `overrun_cnt`. If an overrun occurs in the same cycle, the clear wins and the count ends at 0.
- **Simultaneous `cfg_we` and `frame_start`:** the frame snapshots the pre-write values.
- **Writing D:** `dcnt` resets to 0, so the next `frame_start` is selected.

## Timing
- Reset values: state IDLE, `ptr` = 0, `dcnt` = 0, mask = MASK_RESET, D = 0. All outputs are 0, including `rd_en`, `rd_addr`, `out_*`, `busy`, `frame_done`, `overrun` and `overrun_cnt`.
- Assertion of `rst` mid-sweep returns the block to IDLE immediately; `out_valid` drops asynchronously and the partial frame is abandoned.
- `frame_start` sampled at edge T:
  - `busy` is high from T+1.
  - FETCH occurs in T+1, CAPTURE in T+2.
  - First `out_valid` is at T+3.
- Each sample takes at least 3 cycles: FETCH, CAPTURE, then EMIT for at least 1 cycle.
- `frame_done` is high for exactly the one cycle after the final transfer edge; `busy` is low in that same cycle.
- A frame takes at least 3·(number of enabled channels) cycles.
- All outputs are registered. No combinational path exists from `out_ready` to any output.

## Structure
- Package `acq_pkg` holds:
  - The `sweep_state_t` enum (IDLE/FETCH/CAPTURE/EMIT).
  - Localparams `CFG_MASK = 0`, `CFG_DECIM = 1`, `CFG_CLR = 2`.
  - `OVR_CNT_WIDTH = 8`.
- One sub-module, `chan_mask_next`. It is a combinational priority encoder:
  - Inputs: mask and current index.
  - Outputs: next higher enabled index plus a `none` flag.
  - It is also used with index = −1, i.e. a "first enabled" mode, to find the lowest enabled channel.

## Test plan
1. Reset mask, `out_ready` tied 1, `frame_start` once, `rd_data = 16'h1000 + addr`: sixteen samples on channels 0..15 with data 1000..100F. `out_last` is set on channel 15 only. `frame_done` occurs 48 cycles after `frame_start`.
2. Mask = 16'h8421, random `out_ready` stalls: samples arrive only on channels 0, 5, 10, 15, in order. Data holds stable during stalls. `out_last` is set on channel 15.
3. D = 2, nine `frame_start` pulses spaced 100 cycles apart: frames 1, 4, 7 are swept; the others produce no output and no overrun.
4. Second `frame_start` 10 cycles into a 16-channel sweep: the sweep completes intact, `overrun = 1`, `overrun_cnt = 1`. A write to address 2 clears both to 0.
5. Mask = 0 with `frame_start`: no `out_valid`, and `frame_done` pulses at T+1. Separately, a mask write in the same cycle as `frame_start` results in the old mask being used for that frame.
6. `rst` asserted during EMIT with `out_ready = 0`: `out_valid` goes to 0 and `busy` to 0. The next `frame_start` restarts from channel 0 using MASK_RESET.
